// File: rtl/display_pkg.sv
// Shared 800x600@60 display timing constants (40 MHz pixel clock) and
// pixel-position / pipeline-stage types used by the scan-out datapath.
package display_pkg;

    localparam int unsigned H_CNT_W = 11;
    localparam int unsigned V_CNT_W = 10;

    localparam logic [H_CNT_W-1:0] H_VISIBLE    = 11'd800;
    localparam logic [H_CNT_W-1:0] H_FRONT      = 11'd40;
    localparam logic [H_CNT_W-1:0] H_SYNC       = 11'd128;
    localparam logic [H_CNT_W-1:0] H_BACK       = 11'd88;
    localparam logic [H_CNT_W-1:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [H_CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [H_CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam logic [V_CNT_W-1:0] V_VISIBLE    = 10'd600;
    localparam logic [V_CNT_W-1:0] V_FRONT      = 10'd1;
    localparam logic [V_CNT_W-1:0] V_SYNC       = 10'd4;
    localparam logic [V_CNT_W-1:0] V_BACK       = 10'd23;
    localparam logic [V_CNT_W-1:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [V_CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [V_CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic [H_CNT_W-1:0] h;
        logic [V_CNT_W-1:0] v;
    } pixel_pos_t;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } sync_stage_t;

endpackage

// File: rtl/vga_timing.sv
// Raster counters for 800x600@60 plus undelayed visible/sync/frame-start
// decode; all decodes are forced low while reset is held.
module vga_timing
    import display_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    output pixel_pos_t pos_o,
    output logic       visible_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       frame_start_o
);

    logic [H_CNT_W-1:0] h_q;
    logic [H_CNT_W-1:0] h_d;
    logic [V_CNT_W-1:0] v_q;
    logic [V_CNT_W-1:0] v_d;

    // Next raster position: h every cycle, v on h wrap.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == (H_TOTAL - 11'd1)) begin
            h_d = '0;
            if (v_q == (V_TOTAL - 10'd1)) begin
                v_d = '0;
            end else begin
                v_d = v_q + 10'd1;
            end
        end else begin
            h_d = h_q + 11'd1;
            v_d = v_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Region decode; held low in reset so nothing reaches the pins.
    always_comb begin
        visible_o     = 1'b0;
        hsync_o       = 1'b0;
        vsync_o       = 1'b0;
        frame_start_o = 1'b0;
        if (reset_i) begin
            visible_o     = 1'b0;
            hsync_o       = 1'b0;
            vsync_o       = 1'b0;
            frame_start_o = 1'b0;
        end else begin
            visible_o     = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
            hsync_o       = (h_q >= H_SYNC_START) && (h_q < H_SYNC_END);
            vsync_o       = (v_q >= V_SYNC_START) && (v_q < V_SYNC_END);
            frame_start_o = (h_q == 11'd0) && (v_q == V_VISIBLE);
        end
    end

    assign pos_o = '{h: h_q, v: v_q};

endmodule

// File: rtl/pixel_scanout.sv
// Framebuffer -> palette -> VGA scan-out with 2x upscale and fixed latency 2.
// Optional RGB test pattern enabled by macro PIXEL_SCANOUT_TEST_PATTERN_EN.
module pixel_scanout
    import display_pkg::*;
#(
    parameter int unsigned RESOLUTION_X   = 400,
    parameter int unsigned RESOLUTION_Y   = 300,
    parameter int unsigned PALETTE_LENGTH = 256,
    parameter int unsigned COLOR_BITS     = 12
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
`ifdef PIXEL_SCANOUT_TEST_PATTERN_EN
    input  logic                              test_pattern_i,
`endif
    output logic [$clog2(RESOLUTION_X)-1:0]   fb_rd_x_o,
    output logic [$clog2(RESOLUTION_Y)-1:0]   fb_rd_y_o,
    output logic                              fb_rd_en_o,
    input  logic [$clog2(PALETTE_LENGTH)-1:0] fb_rd_index_i,
    output logic [$clog2(PALETTE_LENGTH)-1:0] palette_rd_index_o,
    input  logic [COLOR_BITS-1:0]             palette_rd_color_i,
    output logic [COLOR_BITS-1:0]             rgb_o,
    output logic                              hsync_o,
    output logic                              vsync_o,
    output logic                              de_o,
    output logic                              frame_start_o
);

    localparam int X_W = $clog2(RESOLUTION_X);
    localparam int Y_W = $clog2(RESOLUTION_Y);

    pixel_pos_t  pos_s;
    logic        visible_s;
    logic        hsync_raw_s;
    logic        vsync_raw_s;
    sync_stage_t st1_d;
    sync_stage_t st1_q;
    sync_stage_t st2_d;
    sync_stage_t st2_q;

    vga_timing u_timing (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .pos_o         (pos_s),
        .visible_o     (visible_s),
        .hsync_o       (hsync_raw_s),
        .vsync_o       (vsync_raw_s),
        .frame_start_o (frame_start_o)
    );

    // Framebuffer request: halve the raster position, park at 0 when blanked.
    always_comb begin
        fb_rd_en_o = visible_s;
        fb_rd_x_o  = '0;
        fb_rd_y_o  = '0;
        if (visible_s) begin
            fb_rd_x_o = X_W'(pos_s.h >> 1);
            fb_rd_y_o = Y_W'(pos_s.v >> 1);
        end else begin
            fb_rd_x_o = '0;
            fb_rd_y_o = '0;
        end
    end

    // Stage 1 forwards the returning index to the palette; blanked slots read entry 0.
    always_comb begin
        palette_rd_index_o = '0;
        if (st1_q.de) begin
            palette_rd_index_o = fb_rd_index_i;
        end else begin
            palette_rd_index_o = '0;
        end
    end

    // Sync/enable pipeline inputs.
    always_comb begin
        st1_d = '{de: visible_s, hsync: hsync_raw_s, vsync: vsync_raw_s};
        st2_d = st1_q;
    end

    // Two-deep sync/enable pipeline matching the fb + palette read latency.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            st1_q <= '0;
            st2_q <= '0;
        end else begin
            st1_q <= st1_d;
            st2_q <= st2_d;
        end
    end

    assign de_o    = st2_q.de;
    assign hsync_o = st2_q.hsync;
    assign vsync_o = st2_q.vsync;

`ifdef PIXEL_SCANOUT_TEST_PATTERN_EN
    logic [X_W-1:0] x1_d;
    logic [X_W-1:0] x1_q;
    logic [X_W-1:0] x2_q;
    logic [Y_W-1:0] y1_d;
    logic [Y_W-1:0] y1_q;
    logic [Y_W-1:0] y2_q;
    logic [15:0]    x2_ext_s;
    logic [15:0]    y2_ext_s;

    // Carry the fb coordinate alongside the sync pipeline for the pattern.
    always_comb begin
        x1_d = fb_rd_x_o;
        y1_d = fb_rd_y_o;
    end

    // Coordinate pipeline registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x1_q <= '0;
            y1_q <= '0;
            x2_q <= '0;
            y2_q <= '0;
        end else begin
            x1_q <= x1_d;
            y1_q <= y1_d;
            x2_q <= x1_q;
            y2_q <= y1_q;
        end
    end

    assign x2_ext_s = 16'(x2_q);
    assign y2_ext_s = 16'(y2_q);

    // Pixel colour: pattern bypasses the palette when selected.
    always_comb begin
        rgb_o = '0;
        if (st2_q.de) begin
            if (test_pattern_i) begin
                rgb_o = COLOR_BITS'({x2_ext_s[7:4], y2_ext_s[7:4], 4'h0});
            end else begin
                rgb_o = palette_rd_color_i;
            end
        end else begin
            rgb_o = '0;
        end
    end
`else
    // Pixel colour straight from the palette, black during blanking.
    always_comb begin
        rgb_o = '0;
        if (st2_q.de) begin
            rgb_o = palette_rd_color_i;
        end else begin
            rgb_o = '0;
        end
    end
`endif

endmodule

// File: doc/pixel_scanout.md
PIXEL_SCANOUT -- requirements
Module: pixel_scanout

Interface
REQ-001 SHALL have parameter RESOLUTION_X, default 400, framebuffer width in pixels.
REQ-002 SHALL have parameter RESOLUTION_Y, default 300, framebuffer height in pixels.
REQ-003 SHALL have parameter PALETTE_LENGTH, default 256, palette entries.
REQ-004 SHALL have parameter COLOR_BITS, default 12, RGB444 colour width.
REQ-005 SHALL have port clk_i  input  1  pixel clock (40 MHz); sole clock.
REQ-006 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port fb_rd_x_o  output  $clog2(RESOLUTION_X)  framebuffer read column.
REQ-008 SHALL have port fb_rd_y_o  output  $clog2(RESOLUTION_Y)  framebuffer read row.
REQ-009 SHALL have port fb_rd_en_o  output  1  framebuffer read strobe.
REQ-010 SHALL have port fb_rd_index_i  input  $clog2(PALETTE_LENGTH)  palette index, valid 1 cycle after fb_rd_en_o.
REQ-011 SHALL have port palette_rd_index_o  output  $clog2(PALETTE_LENGTH)  palette read address.
REQ-012 SHALL have port palette_rd_color_i  input  COLOR_BITS  colour, valid 1 cycle after address.
REQ-013 SHALL have ports rgb_o  output  COLOR_BITS; hsync_o, vsync_o, de_o  output  1  each; VGA pins.
REQ-014 SHALL have port frame_start_o  output  1  one-cycle pulse at start of vertical blank.

Function
REQ-015 SHALL count h 0..1055 and v 0..627 (800x600@60: H 800/40/128/88, V 600/1/4/23); h increments every cycle, v increments when h wraps 1055->0, v wraps 627->0.
REQ-016 SHALL define visible as h<800 and v<600; fb_rd_en_o = visible; fb_rd_x_o = h>>1, fb_rd_y_o = v>>1 (fixed 2x upscale), both forced 0 outside visible.
REQ-017 SHALL drive palette_rd_index_o = fb_rd_index_i registered-free (combinational pass-through) in pipeline stage 1.
REQ-018 SHALL align outputs at fixed latency 2: de_o, hsync_o, vsync_o and rgb_o at cycle t+2 correspond to counter state at cycle t.
REQ-019 SHALL assert hsync (pre-delay) for 840<=h<968 and vsync for 601<=v<605, positive polarity.
REQ-020 SHALL drive rgb_o = palette_rd_color_i when delayed de is 1, else 0.
REQ-021 SHALL pulse frame_start_o for exactly one cycle when h=0 and v=600 (undelayed).
REQ-022 SHALL ignore fb_rd_index_i and palette_rd_color_i when the matching pipeline slot is not visible.

Reset
REQ-023 SHALL, while reset_i high, hold h=0, v=0, all pipeline registers 0, rgb_o=0, hsync_o=0, vsync_o=0, de_o=0, frame_start_o=0.
REQ-024 SHALL, on reset mid-frame, abandon the frame immediately and restart at h=0, v=0 on the first clock edge after release; first valid de_o 2 cycles later.

Configuration
REQ-025 SHALL, when macro PIXEL_SCANOUT_TEST_PATTERN_EN is defined, add input test_pattern_i (1 bit); when high, rgb_o in visible = {x[7:4], y[7:4], 4'h0} of the delayed fb coordinate, bypassing palette; timing unchanged.
REQ-026 SHALL, without PIXEL_SCANOUT_TEST_PATTERN_EN, have no test_pattern_i port and no pattern logic.

Structure
REQ-027 SHALL place H/V visible, front-porch, sync, back-porch constants and a pixel-position struct typedef in shared package display_pkg.
REQ-028 SHALL instantiate one sub-module vga_timing (h/v counters, visible, raw hsync/vsync, frame_start).

Verification
REQ-029 SHALL test reset: hold reset_i 5 cycles -> all outputs 0; release -> de_o rises exactly 2 cycles later.
REQ-030 SHALL test pixel path: fb model returns 0x5A at (0,0), palette[0x5A]=0xABC -> first de_o cycle rgb_o=0xABC; pixels h=0,1 both read fb_rd_x_o=0.
REQ-031 SHALL test line timing: hsync_o high exactly 128 cycles, rising 842 cycles after line start; de_o high 800 cycles per line.
REQ-032 SHALL test frame: 1056*628=663168 cycles between frame_start_o pulses; vsync_o high 4 lines; de_o low during rows 600..627.
REQ-033 SHALL test reset asserted at h=500, v=300 -> outputs 0 within same cycle (async), restart at h=0, v=0.
REQ-034 SHALL test, with PIXEL_SCANOUT_TEST_PATTERN_EN and test_pattern_i=1, fb coordinate (0x35,0x9C) -> rgb_o=0x390.
